// File: rtl/alu_register_file.sv
// General register file with dual read ports, 8-op ALU with registered flags,
// and a sequential shift-add unsigned multiplier.
//
// state  | meaning
// S_IDLE | multiplier waiting for MS
// S_RUN  | one shift-add iteration per clock, BUSY high
// S_DONE | PROD freshly loaded, DONE pulse for one cycle
module alu_register_file #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           bus,
  input  logic                       RI,
  input  logic [$clog2(NREGS)-1:0]   WSEL,
  input  logic [$clog2(NREGS)-1:0]   ASEL,
  input  logic [$clog2(NREGS)-1:0]   BSEL,
  input  logic [2:0]                 OP,
  input  logic                       FI,
  input  logic                       MS,
  output logic [WIDTH-1:0]           A_out,
  output logic [WIDTH-1:0]           B_out,
  output logic [WIDTH-1:0]           E_out,
  output logic                       CARRY,
  output logic                       ZERO,
  output logic                       NEG,
  output logic                       OVF,
  output logic [2*WIDTH-1:0]         PROD,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic               carry_q, zero_q, neg_q, ovf_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   b_eff;
  logic               ovf;
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_next, prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (RI) begin
      regs_q[WSEL] <= bus;
    end
  end

  assign A_out = regs_q[ASEL];
  assign B_out = regs_q[BSEL];

  // SUB (001) and SBC (011) add the inverted B operand
  assign b_eff = (OP[0] && !OP[2]) ? ~B_out : B_out;

  always_comb begin
    sum = '0;
    ovf = 1'b0;
    case (OP)
      3'b000:  sum = {1'b0, A_out} + {1'b0, b_eff};
      3'b001:  sum = {1'b0, A_out} + {1'b0, b_eff} + (WIDTH+1)'(1);
      3'b010:  sum = {1'b0, A_out} + {1'b0, b_eff} + (WIDTH+1)'(carry_q);
      3'b011:  sum = {1'b0, A_out} + {1'b0, b_eff} + (WIDTH+1)'(carry_q);
      3'b100:  sum = {1'b0, A_out & B_out};
      3'b101:  sum = {1'b0, A_out | B_out};
      3'b110:  sum = {1'b0, A_out ^ B_out};
      default: sum = {A_out, 1'b0};
    endcase
    if (!OP[2])
      ovf = (A_out[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A_out[WIDTH-1]);
    else if (OP == 3'b111)
      ovf = A_out[WIDTH-1] ^ A_out[WIDTH-2];
  end

  assign E_out = sum[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (FI) begin
      carry_q <= sum[WIDTH];
      zero_q  <= (sum[WIDTH-1:0] == '0);
      neg_q   <= sum[WIDTH-1];
      ovf_q   <= ovf;
    end
  end

  assign CARRY = carry_q;
  assign ZERO  = zero_q;
  assign NEG   = neg_q;
  assign OVF   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      default: state_d = MS ? S_RUN : S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_q)
      S_RUN:   BUSY = 1'b1;
      S_DONE:  DONE = 1'b1;
      default: ;
    endcase
  end

  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

  // Operands are captured at start so later register writes cannot disturb a run
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else if (state_q == S_RUN) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == '0) prod_q <= acc_next;
    end else if (MS) begin
      mcand_q  <= {{WIDTH{1'b0}}, A_out};
      mplier_q <= B_out;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH-1);
    end
  end

  assign PROD = prod_q;

endmodule

// File: tb/tb_alu_register_file.sv
// Directed bench for alu_register_file at WIDTH=8, NREGS=4.
module tb_alu_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus;
  logic        RI;
  logic [1:0]  WSEL, ASEL, BSEL;
  logic [2:0]  OP;
  logic        FI, MS;
  logic [7:0]  A_out, B_out, E_out;
  logic        CARRY, ZERO, NEG, OVF;
  logic [15:0] PROD;
  logic        BUSY, DONE;

  int n_vec = 0;
  int n_err = 0;

  alu_register_file #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .RI(RI), .WSEL(WSEL), .ASEL(ASEL),
    .BSEL(BSEL), .OP(OP), .FI(FI), .MS(MS), .A_out(A_out), .B_out(B_out),
    .E_out(E_out), .CARRY(CARRY), .ZERO(ZERO), .NEG(NEG), .OVF(OVF),
    .PROD(PROD), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [7:0] val);
    RI = 1'b1; WSEL = idx; bus = val;
    step();
    RI = 1'b0;
  endtask

  task automatic test_reset();
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    ASEL = 2'd3; BSEL = 2'd1; #1;
    n_vec++;
    if ({A_out, B_out} !== 16'h4422) begin
      n_err++; $display("FAIL preload_read got %h want 4422", {A_out, B_out});
    end
    rst = 1'b1; RI = 1'b1; FI = 1'b1; MS = 1'b1; bus = 8'hAA;
    step();
    rst = 1'b0; RI = 1'b0; FI = 1'b0; MS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ASEL = 2'(i); BSEL = 2'(3 - i); #1;
      n_vec++;
      if ({A_out, B_out} !== 16'h0000) begin
        n_err++; $display("FAIL reset_regs sel %0d got %h want 0000", i, {A_out, B_out});
      end
    end
    n_vec++;
    if ({CARRY, ZERO, NEG, OVF, BUSY, DONE, PROD} !== 22'h0) begin
      n_err++; $display("FAIL reset_state got %b want all zero",
                        {CARRY, ZERO, NEG, OVF, BUSY, DONE, PROD});
    end
  endtask

  task automatic test_add();
    wr(2'd0, 8'hFF); wr(2'd1, 8'h01);
    ASEL = 2'd0; BSEL = 2'd1; OP = 3'b000; #1;
    n_vec++;
    if (E_out !== 8'h00) begin n_err++; $display("FAIL add_ff_01 got %h want 00", E_out); end
    FI = 1'b1; step(); FI = 1'b0;
    n_vec++;
    if ({CARRY, ZERO, NEG, OVF} !== 4'b1100) begin
      n_err++; $display("FAIL add_ff_01_flags got %b want 1100", {CARRY, ZERO, NEG, OVF});
    end
    wr(2'd0, 8'h7F); #1;
    n_vec++;
    if (E_out !== 8'h80) begin n_err++; $display("FAIL add_7f_01 got %h want 80", E_out); end
    FI = 1'b1; step(); FI = 1'b0;
    n_vec++;
    if ({CARRY, ZERO, NEG, OVF} !== 4'b0011) begin
      n_err++; $display("FAIL add_7f_01_flags got %b want 0011", {CARRY, ZERO, NEG, OVF});
    end
  endtask

  task automatic test_sub_chain();
    logic [7:0] lo, hi;
    wr(2'd0, 8'h00); wr(2'd1, 8'h01); wr(2'd2, 8'h01); wr(2'd3, 8'h00);
    ASEL = 2'd0; BSEL = 2'd1; OP = 3'b001; #1;
    lo = E_out;
    FI = 1'b1; step(); FI = 1'b0;
    n_vec++;
    if ({lo, CARRY} !== 9'b1111_1111_0) begin
      n_err++; $display("FAIL sub_lo got %h c=%b want ff c=0", lo, CARRY);
    end
    ASEL = 2'd2; BSEL = 2'd3; OP = 3'b011; #1;
    hi = E_out;
    FI = 1'b1; step(); FI = 1'b0;
    n_vec++;
    if ({hi, lo, CARRY, ZERO} !== 18'b0000_0000_1111_1111_11) begin
      n_err++; $display("FAIL sbc_chain got %h c=%b z=%b want 00ff c=1 z=1", {hi, lo}, CARRY, ZERO);
    end
    // ADC with CARRY=1: 01+00+1 = 02
    OP = 3'b010; #1;
    n_vec++;
    if (E_out !== 8'h02) begin n_err++; $display("FAIL adc_carry got %h want 02", E_out); end
  endtask

  task automatic test_logic();
    wr(2'd0, 8'hC3); wr(2'd1, 8'h5A);
    ASEL = 2'd0; BSEL = 2'd1;
    OP = 3'b100; #1;
    n_vec++;
    if (E_out !== 8'h42) begin n_err++; $display("FAIL and got %h want 42", E_out); end
    OP = 3'b101; #1;
    n_vec++;
    if (E_out !== 8'hDB) begin n_err++; $display("FAIL or got %h want db", E_out); end
    OP = 3'b110; #1;
    n_vec++;
    if (E_out !== 8'h99) begin n_err++; $display("FAIL xor got %h want 99", E_out); end
    FI = 1'b1; step(); FI = 1'b0;
    n_vec++;
    if ({CARRY, ZERO, NEG, OVF} !== 4'b0010) begin
      n_err++; $display("FAIL xor_flags got %b want 0010", {CARRY, ZERO, NEG, OVF});
    end
    OP = 3'b111; #1;
    n_vec++;
    if (E_out !== 8'h86) begin n_err++; $display("FAIL shl got %h want 86", E_out); end
    FI = 1'b1; step(); FI = 1'b0;
    n_vec++;
    if ({CARRY, ZERO, NEG, OVF} !== 4'b1010) begin
      n_err++; $display("FAIL shl_flags got %b want 1010", {CARRY, ZERO, NEG, OVF});
    end
    wr(2'd0, 8'h40); OP = 3'b111; #1;
    n_vec++;
    if (E_out !== 8'h80) begin n_err++; $display("FAIL shl_40 got %h want 80", E_out); end
    FI = 1'b1; step(); FI = 1'b0;
    n_vec++;
    if ({CARRY, ZERO, NEG, OVF} !== 4'b0011) begin
      n_err++; $display("FAIL shl_40_flags got %b want 0011", {CARRY, ZERO, NEG, OVF});
    end
    // FI low: flags hold even though the ALU result would set them differently
    OP = 3'b100; BSEL = 2'd2; wr(2'd2, 8'h00);
    step();
    n_vec++;
    if ({CARRY, ZERO, NEG, OVF} !== 4'b0011) begin
      n_err++; $display("FAIL flag_hold got %b want 0011", {CARRY, ZERO, NEG, OVF});
    end
  endtask

  task automatic test_write_bypass();
    wr(2'd2, 8'h11);
    RI = 1'b1; WSEL = 2'd2; ASEL = 2'd2; bus = 8'h55; #1;
    n_vec++;
    if (A_out !== 8'h11) begin n_err++; $display("FAIL write_old got %h want 11", A_out); end
    step(); RI = 1'b0;
    n_vec++;
    if (A_out !== 8'h55) begin n_err++; $display("FAIL write_new got %h want 55", A_out); end
  endtask

  task automatic test_mult();
    wr(2'd0, 8'hFF); wr(2'd1, 8'hFF);
    ASEL = 2'd0; BSEL = 2'd1; MS = 1'b1;
    step(); MS = 1'b0;
    n_vec++;
    if ({BUSY, DONE, PROD} !== {2'b10, 16'h0000}) begin
      n_err++; $display("FAIL mult_start got busy=%b done=%b prod=%h want 1 0 0000", BUSY, DONE, PROD);
    end
    for (int c = 1; c < 8; c++) begin
      if (c == 2) begin RI = 1'b1; WSEL = 2'd0; bus = 8'h02; MS = 1'b1; FI = 1'b1; end
      step();
      RI = 1'b0; MS = 1'b0; FI = 1'b0;
      n_vec++;
      if ({BUSY, DONE} !== 2'b10) begin
        n_err++; $display("FAIL mult_run cyc %0d got busy=%b done=%b want 1 0", c, BUSY, DONE);
      end
    end
    step();
    n_vec++;
    if ({BUSY, DONE, PROD} !== {2'b01, 16'hFE01}) begin
      n_err++; $display("FAIL mult_ff_ff got busy=%b done=%b prod=%h want 0 1 fe01", BUSY, DONE, PROD);
    end
  endtask

  // Entered in the DONE cycle of test_mult: restart immediately with r0=02, r1=FF
  task automatic test_back_to_back();
    MS = 1'b1;
    step(); MS = 1'b0;
    n_vec++;
    if ({BUSY, DONE, PROD} !== {2'b10, 16'hFE01}) begin
      n_err++; $display("FAIL b2b_start got busy=%b done=%b prod=%h want 1 0 fe01", BUSY, DONE, PROD);
    end
    repeat (7) step();
    step();
    n_vec++;
    if ({BUSY, DONE, PROD} !== {2'b01, 16'h01FE}) begin
      n_err++; $display("FAIL b2b_done got busy=%b done=%b prod=%h want 0 1 01fe", BUSY, DONE, PROD);
    end
    step();
    n_vec++;
    if ({BUSY, DONE, PROD} !== {2'b00, 16'h01FE}) begin
      n_err++; $display("FAIL b2b_idle got busy=%b done=%b prod=%h want 0 0 01fe", BUSY, DONE, PROD);
    end
  endtask

  task automatic test_rst_mid();
    wr(2'd0, 8'h03); wr(2'd1, 8'h04);
    ASEL = 2'd0; BSEL = 2'd1; MS = 1'b1;
    step(); MS = 1'b0;
    step(); step();
    rst = 1'b1;
    step(); rst = 1'b0;
    n_vec++;
    if ({BUSY, DONE, PROD} !== 18'h0) begin
      n_err++; $display("FAIL rst_mid got busy=%b done=%b prod=%h want 0 0 0000", BUSY, DONE, PROD);
    end
    wr(2'd0, 8'h03); wr(2'd1, 8'h04);
    MS = 1'b1;
    step(); MS = 1'b0;
    repeat (7) step();
    step();
    n_vec++;
    if ({BUSY, DONE, PROD} !== {2'b01, 16'h000C}) begin
      n_err++; $display("FAIL restart got busy=%b done=%b prod=%h want 0 1 000c", BUSY, DONE, PROD);
    end
  endtask

  initial begin
    rst = 1'b1; bus = '0; RI = 1'b0; WSEL = '0; ASEL = '0; BSEL = '0;
    OP = '0; FI = 1'b0; MS = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    test_reset();
    test_add();
    test_sub_chain();
    test_logic();
    test_write_bypass();
    test_mult();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
